// File: rtl/loop_buffer_pkg.sv
// Shared types and constants for the loop buffer write-side framer.
package loop_buffer_pkg;

    typedef enum logic [1:0] {
        IDLE,
        WRITE,
        PAD,
        DROP
    } wr_state_e;

    localparam int unsigned BLK_CNT_W = 16;

    function automatic int unsigned credit_width(input int unsigned loop_w,
                                                 input int unsigned waddr_w);
        return loop_w - waddr_w + 1;
    endfunction

endpackage

// File: rtl/loop_buffer_wr_ctrl.sv
// Frames a valid/ready word stream into fixed-length loop buffer block writes,
// padding short source blocks and truncating long ones.
module loop_buffer_wr_ctrl
    import loop_buffer_pkg::*;
#(
    parameter int unsigned WDATA_WIDTH = 64,
    parameter int unsigned WADDR_WIDTH = 8,
    parameter int unsigned LOOP_WIDTH  = 9,
    parameter int unsigned INFO_WIDTH  = 256,
    parameter int unsigned BLOCK_LEN   = 256
) (
    input  logic                                          wr_clk,
    input  logic                                          wr_rst,
    input  logic [WDATA_WIDTH-1:0]                        s_data,
    input  logic                                          s_valid,
    input  logic                                          s_last,
    input  logic [INFO_WIDTH-1:0]                         s_info,
    output logic                                          s_ready,
    input  logic [credit_width(LOOP_WIDTH, WADDR_WIDTH)-1:0] free_size,
    input  logic                                          wr_rdy,
    output logic [WADDR_WIDTH-1:0]                        wr_addr,
    output logic [WDATA_WIDTH-1:0]                        wr_data,
    output logic                                          wr_wen,
    output logic                                          wr_wlast,
    output logic [INFO_WIDTH-1:0]                         wr_info,
    output logic [BLK_CNT_W-1:0]                          blk_cnt,
    output logic                                          err_short,
    output logic                                          err_long
);

    localparam logic [WADDR_WIDTH-1:0] LAST_ADDR = WADDR_WIDTH'(BLOCK_LEN - 1);

    wr_state_e              state_q, state_d;
    logic [WADDR_WIDTH-1:0] wcnt_q, wcnt_d;
    logic [WADDR_WIDTH-1:0] addr_q, addr_d;
    logic [WDATA_WIDTH-1:0] data_q, data_d;
    logic                   wen_q, wen_d;
    logic                   wlast_q, wlast_d;
    logic [INFO_WIDTH-1:0]  info_q, info_d;
    logic [BLK_CNT_W-1:0]   blk_q, blk_d;
    logic                   es_q, es_d;
    logic                   el_q, el_d;

    logic credit_ok;
    logic accept;

    assign credit_ok = (free_size != '0) && wr_rdy;
    // Held low during reset so every output reads 0 while wr_rst is high.
    assign s_ready   = !wr_rst &&
                       (((state_q == IDLE) && credit_ok) ||
                        (state_q == WRITE) || (state_q == DROP));
    assign accept    = s_valid && s_ready;

    always_comb begin
        state_d = state_q;
        wcnt_d  = wcnt_q;
        addr_d  = addr_q;
        data_d  = data_q;
        wen_d   = 1'b0;
        wlast_d = 1'b0;
        info_d  = info_q;
        blk_d   = blk_q;
        es_d    = es_q;
        el_d    = el_q;
        case (state_q)
            IDLE: begin
                if (accept) begin
                    wen_d  = 1'b1;
                    addr_d = '0;
                    data_d = s_data;
                    info_d = s_info;
                    wcnt_d = WADDR_WIDTH'(1);
                    if (s_last) begin
                        state_d = PAD;
                        es_d    = 1'b1;
                    end else begin
                        state_d = WRITE;
                    end
                end
            end
            WRITE: begin
                if (accept) begin
                    wen_d  = 1'b1;
                    addr_d = wcnt_q;
                    data_d = s_data;
                    if (wcnt_q == LAST_ADDR) begin
                        wlast_d = 1'b1;
                        wcnt_d  = '0;
                        blk_d   = blk_q + 1'b1;
                        if (s_last) begin
                            state_d = IDLE;
                        end else begin
                            state_d = DROP;
                            el_d    = 1'b1;
                        end
                    end else begin
                        wcnt_d = wcnt_q + 1'b1;
                        if (s_last) begin
                            state_d = PAD;
                            es_d    = 1'b1;
                        end
                    end
                end
            end
            PAD: begin
                wen_d  = 1'b1;
                addr_d = wcnt_q;
                data_d = '0;
                if (wcnt_q == LAST_ADDR) begin
                    wlast_d = 1'b1;
                    wcnt_d  = '0;
                    blk_d   = blk_q + 1'b1;
                    state_d = IDLE;
                end else begin
                    wcnt_d = wcnt_q + 1'b1;
                end
            end
            DROP: begin
                if (accept && s_last) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge wr_clk) begin
        if (wr_rst) begin
            state_q <= IDLE;
            wcnt_q  <= '0;
            addr_q  <= '0;
            data_q  <= '0;
            wen_q   <= 1'b0;
            wlast_q <= 1'b0;
            info_q  <= '0;
            blk_q   <= '0;
            es_q    <= 1'b0;
            el_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            wcnt_q  <= wcnt_d;
            addr_q  <= addr_d;
            data_q  <= data_d;
            wen_q   <= wen_d;
            wlast_q <= wlast_d;
            info_q  <= info_d;
            blk_q   <= blk_d;
            es_q    <= es_d;
            el_q    <= el_d;
        end
    end

    assign wr_addr   = addr_q;
    assign wr_data   = data_q;
    assign wr_wen    = wen_q;
    assign wr_wlast  = wlast_q;
    assign wr_info   = info_q;
    assign blk_cnt   = blk_q;
    assign err_short = es_q;
    assign err_long  = el_q;

endmodule

// File: tb/tb_loop_buffer_wr_ctrl.sv
// Directed bench for loop_buffer_wr_ctrl: a block-level model predicts the
// write sequence of each source block and every cycle is compared against it.
module tb_loop_buffer_wr_ctrl;

    localparam int unsigned DW = 16;
    localparam int unsigned AW = 8;
    localparam int unsigned IW = 32;
    localparam int unsigned BL = 4;

    logic          clk;
    logic          wr_rst;
    logic [DW-1:0] s_data;
    logic          s_valid;
    logic          s_last;
    logic [IW-1:0] s_info;
    logic          s_ready;
    logic [1:0]    free_size;
    logic          wr_rdy;
    logic [AW-1:0] wr_addr;
    logic [DW-1:0] wr_data;
    logic          wr_wen;
    logic          wr_wlast;
    logic [IW-1:0] wr_info;
    logic [15:0]   blk_cnt;
    logic          err_short;
    logic          err_long;

    loop_buffer_wr_ctrl #(
        .WDATA_WIDTH(DW),
        .WADDR_WIDTH(AW),
        .LOOP_WIDTH (9),
        .INFO_WIDTH (IW),
        .BLOCK_LEN  (BL)
    ) dut (
        .wr_clk   (clk),
        .wr_rst   (wr_rst),
        .s_data   (s_data),
        .s_valid  (s_valid),
        .s_last   (s_last),
        .s_info   (s_info),
        .s_ready  (s_ready),
        .free_size(free_size),
        .wr_rdy   (wr_rdy),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .wr_wen   (wr_wen),
        .wr_wlast (wr_wlast),
        .wr_info  (wr_info),
        .blk_cnt  (blk_cnt),
        .err_short(err_short),
        .err_long (err_long)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic          last;
        logic [IW-1:0] info;
    } wr_t;

    wr_t         exp_q[$];
    logic [15:0] m_blk;
    logic        m_short;
    logic        m_long;
    int          n_chk;
    int          n_err;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        n_chk++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s actual=%0h required=%0h at %0t", name, act, req, $time);
        end
    endtask

    // One clock cycle; outputs are compared #1 after the rising edge.
    task automatic tick();
        wr_t e;
        @(posedge clk);
        #1;
        if (wr_rst) begin
            chk("rst_wen", wr_wen, 0);
            chk("rst_wlast", wr_wlast, 0);
            chk("rst_addr", wr_addr, 0);
            chk("rst_data", wr_data, 0);
            chk("rst_info", wr_info, 0);
            chk("rst_blk_cnt", blk_cnt, 0);
            chk("rst_err_short", err_short, 0);
            chk("rst_err_long", err_long, 0);
            chk("rst_s_ready", s_ready, 0);
        end else if (wr_wen) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_write", wr_wen, 0);
            end else begin
                e = exp_q.pop_front();
                chk("wr_addr", wr_addr, e.addr);
                chk("wr_data", wr_data, e.data);
                chk("wr_wlast", wr_wlast, e.last);
                if (e.last) begin
                    m_blk++;
                    chk("wr_info", wr_info, e.info);
                    chk("blk_cnt", blk_cnt, m_blk);
                    chk("err_short", err_short, m_short);
                    chk("err_long", err_long, m_long);
                end
            end
        end else begin
            chk("wlast_without_wen", wr_wlast, 0);
        end
    endtask

    task automatic drain(input int n);
        repeat (n) tick();
        chk("pending_writes", exp_q.size(), 0);
    endtask

    task automatic send_word(input logic [DW-1:0] d, input logic last,
                             input logic [IW-1:0] info, input logic exp_w);
        logic acc;
        s_valid = 1'b1;
        s_data  = d;
        s_last  = last;
        s_info  = info;
        acc     = 1'b0;
        for (int c = 0; c < 50 && !acc; c++) begin
            @(negedge clk);
            acc = s_ready;
            tick();
        end
        chk("accept_timeout", acc, 1);
        if (acc) chk("wen_latency", wr_wen, exp_w);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    // Model: a source block of n words maps to exactly BL writes; words past BL
    // are dropped, missing words are written as zero.
    task automatic send_block(input int n, input logic [DW-1:0] base,
                              input logic [IW-1:0] info, input logic gap,
                              input logic drop_credit);
        wr_t e;
        for (int i = 0; i < BL; i++) begin
            e.addr = AW'(i);
            e.data = (i < n) ? DW'(base + DW'(i)) : '0;
            e.last = (i == BL - 1);
            e.info = info;
            exp_q.push_back(e);
        end
        if (n < BL) m_short = 1'b1;
        if (n > BL) m_long  = 1'b1;
        for (int i = 0; i < n; i++) begin
            send_word(DW'(base + DW'(i)), (i == n - 1),
                      (i == 0) ? info : (info ^ IW'(32'h0101_0101 * i)), (i < BL));
            if (i == 0 && drop_credit) free_size = 2'd0;
            if (gap && i < n - 1) tick();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog_timeout actual=running required=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int cnt;
        wr_t e;
        n_chk = 0; n_err = 0;
        m_blk = '0; m_short = 1'b0; m_long = 1'b0;
        wr_rst = 1'b1; s_valid = 1'b0; s_last = 1'b0; s_data = '0; s_info = '0;
        free_size = 2'd2; wr_rdy = 1'b1;
        tick(); tick();
        wr_rst = 1'b0;

        // Nominal: two back-to-back blocks, data 1..8.
        send_block(4, 16'd1, 32'hA1, 1'b0, 1'b0);
        send_block(4, 16'd5, 32'hA2, 1'b0, 1'b0);
        drain(3);
        chk("nominal_blk_cnt", blk_cnt, 2);
        chk("nominal_err_short", err_short, 0);
        chk("nominal_err_long", err_long, 0);

        // Credit stall: no credit means no acceptance and no writes.
        free_size = 2'd0; s_valid = 1'b1; s_data = 16'd9; s_last = 1'b0; s_info = 32'hB1;
        repeat (3) begin
            @(negedge clk);
            chk("credit_stall_ready", s_ready, 0);
            tick();
        end
        free_size = 2'd1;
        send_block(4, 16'd9, 32'hB1, 1'b0, 1'b0);
        drain(3);
        chk("credit_blk_cnt", blk_cnt, 3);
        free_size = 2'd2;

        // Short block: A,B then two zero pad words; stream is held off meanwhile.
        send_block(2, 16'hA, 32'hC1, 1'b0, 1'b0);
        cnt = 0;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (s_ready) break;
            cnt++;
            tick();
        end
        chk("pad_ready_low_cycles", cnt, 2);
        drain(2);
        chk("short_err_short", err_short, 1);
        chk("short_err_long", err_long, 0);
        chk("short_blk_cnt", blk_cnt, 4);

        // Long block: six words, last two dropped.
        send_block(6, 16'h20, 32'hD1, 1'b0, 1'b0);
        drain(3);
        chk("long_err_long", err_long, 1);
        chk("long_blk_cnt", blk_cnt, 5);

        // Info integrity, with a wr_rdy stall at block start.
        wr_rdy = 1'b0; s_valid = 1'b1; s_data = 16'h30; s_last = 1'b0; s_info = 32'hAA;
        repeat (3) begin
            @(negedge clk);
            chk("rdy_stall_ready", s_ready, 0);
            tick();
        end
        wr_rdy = 1'b1;
        send_block(4, 16'h30, 32'hAA, 1'b0, 1'b0);
        drain(3);
        chk("info_held", wr_info, 32'hAA);
        chk("info_blk_cnt", blk_cnt, 6);

        // Valid gaps inside a block, credit withdrawn after the first word.
        send_block(4, 16'h40, 32'hE1, 1'b1, 1'b1);
        drain(3);
        chk("gap_blk_cnt", blk_cnt, 7);
        free_size = 2'd2;

        // Reset after two words of a block: the block is abandoned.
        e.info = 32'hF1; e.last = 1'b0;
        e.addr = 8'd0; e.data = 16'h51; exp_q.push_back(e);
        e.addr = 8'd1; e.data = 16'h52; exp_q.push_back(e);
        send_word(16'h51, 1'b0, 32'hF1, 1'b1);
        send_word(16'h52, 1'b0, 32'hF1, 1'b1);
        chk("pre_reset_pending", exp_q.size(), 0);
        wr_rst = 1'b1;
        tick(); tick();
        wr_rst = 1'b0;
        m_blk = '0; m_short = 1'b0; m_long = 1'b0;
        chk("post_reset_blk_cnt", blk_cnt, 0);
        chk("post_reset_err_short", err_short, 0);
        send_block(4, 16'h60, 32'hF2, 1'b0, 1'b0);
        drain(3);
        chk("restart_blk_cnt", blk_cnt, 1);
        chk("restart_info", wr_info, 32'hF2);

        $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
        $finish;
    end

endmodule
